// File: rtl/serial_frame_tx_if.sv
// Word handshake between the word source and serial_frame_tx.
// Master drives valid/data, slave returns ready.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble of ones, 0 delimiter, then
// an MSB-first payload with a 0 stuffed after every MAX_RUN ones.
module serial_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int PRE_LEN = 3,
    parameter int MAX_RUN = 2
) (
    input  logic             clk,
    input  logic             reset,
    serial_frame_tx_if.slave in_if,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             frame_done
);
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int RW = $clog2(MAX_RUN + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RUN);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DELIM,
        DATA,
        STUFF
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [RW-1:0]     run_q, run_d;
    logic              tx_bit_d;
    logic              tx_active_d;
    logic              done_d;
    logic              load_bit;
    logic              nxt_bit;
    logic [RW-1:0]     run_base;

    assign in_if.in_ready = (state_q == IDLE);

    // State names the bit currently on the line; outputs are
    // registered from the state being entered.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pre_d       = pre_q;
        bits_d      = bits_q;
        run_d       = run_q;
        tx_bit_d    = 1'b0;
        tx_active_d = 1'b0;
        done_d      = 1'b0;
        load_bit    = 1'b0;
        nxt_bit     = shift_q[DATA_W-1];
        run_base    = (state_q == DELIM) ? '0 : run_q;

        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    state_d     = PRE;
                    shift_d     = in_if.in_data;
                    pre_d       = PW'(1);
                    bits_d      = '0;
                    run_d       = '0;
                    tx_bit_d    = 1'b1;
                    tx_active_d = 1'b1;
                end
            end
            PRE: begin
                tx_active_d = 1'b1;
                if (pre_q == PRE_MAX) begin
                    state_d = DELIM;
                end else begin
                    pre_d    = pre_q + 1'b1;
                    tx_bit_d = 1'b1;
                end
            end
            DELIM: begin
                load_bit = 1'b1;
            end
            DATA: begin
                if (run_q == RUN_MAX) begin
                    state_d     = STUFF;
                    run_d       = '0;
                    tx_active_d = 1'b1;
                end else if (bits_q == BIT_MAX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    load_bit = 1'b1;
                end
            end
            STUFF: begin
                if (bits_q == BIT_MAX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    load_bit = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_bit) begin
            state_d     = DATA;
            tx_bit_d    = nxt_bit;
            tx_active_d = 1'b1;
            shift_d     = shift_q << 1;
            bits_d      = bits_q + 1'b1;
            run_d       = nxt_bit ? run_base + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            pre_q      <= '0;
            bits_q     <= '0;
            run_q      <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pre_q      <= pre_d;
            bits_q     <= bits_d;
            run_q      <= run_d;
            tx_bit     <= tx_bit_d;
            tx_active  <= tx_active_d;
            frame_done <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed and random words against
// a bit-queue frame model.
module tb_serial_frame_tx;
    localparam int DATA_W  = 8;
    localparam int PRE_LEN = 3;
    localparam int MAX_RUN = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_bit;
    logic tx_active;
    logic frame_done;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    serial_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_tx #(
        .DATA_W (DATA_W),
        .PRE_LEN(PRE_LEN),
        .MAX_RUN(MAX_RUN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (bus),
        .tx_bit    (tx_bit),
        .tx_active (tx_active),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame = ones preamble, 0, payload MSB first with a 0 after
    // every MAX_RUN consecutive payload ones.
    task automatic build(input logic [DATA_W-1:0] w);
        int run;
        run = 0;
        exp_q.delete();
        repeat (PRE_LEN) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            exp_q.push_back(w[i]);
            run = w[i] ? run + 1 : 0;
            if (run == MAX_RUN) begin
                exp_q.push_back(1'b0);
                run = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_bit", 32'(tx_bit), 32'd0);
            chk("idle_active", 32'(tx_active), 32'd0);
            chk("idle_done", 32'(frame_done), 32'd0);
            chk("idle_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input bit noisy,
                        input int abort_at);
        build(w);
        chk("ready_before", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("bit%0d_w%02h", i, w), 32'(tx_bit),
                32'(exp_q[i]));
            chk("active", 32'(tx_active), 32'd1);
            chk("busy_ready", 32'(bus.in_ready), 32'd0);
            chk("busy_done", 32'(frame_done), 32'd0);
            bus.in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) bus.in_data = DATA_W'($urandom);
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                bus.in_valid = 1'b0;
                chk("rst_bit", 32'(tx_bit), 32'd0);
                chk("rst_active", 32'(tx_active), 32'd0);
                chk("rst_ready", 32'(bus.in_ready), 32'd1);
                chk("rst_done", 32'(frame_done), 32'd0);
                return;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("end_bit", 32'(tx_bit), 32'd0);
        chk("end_active", 32'(tx_active), 32'd0);
        chk("end_done", 32'(frame_done), 32'd1);
        chk("end_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_bit", 32'(tx_bit), 32'd0);
        chk("reset_active", 32'(tx_active), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        idle(2);

        send(8'hA5, 1'b0, -1);
        idle(1);
        send(8'hFF, 1'b0, -1);
        idle(1);
        send(8'h6C, 1'b0, -1);
        idle(2);

        send(8'h00, 1'b0, -1);
        send(8'h81, 1'b0, -1);
        idle(1);

        send(8'h3B, 1'b1, -1);
        idle(1);

        send(8'hA5, 1'b0, PRE_LEN + 1 + 5);
        idle(2);
        send(8'hE7, 1'b0, -1);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            send(DATA_W'($urandom), 1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
